// File: rtl/pc_gen.sv
// pc_gen: fetch-PC generator with prioritised redirect channels and a
// one-entry pending-redirect buffer. Drives pc_o to IF via a valid/ready
// handshake (accept = pc_valid_o & fetch_ready_i).
// Optional feature macro: ADDR_ERR_CHECK_EN. When it is defined, misaligned
// redirect targets are loaded unmodified and flagged on addr_err_o. When it is
// undefined, target bits [1:0] are cleared on load and addr_err_o is tied 0.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'hBFC00000,
  parameter int                FETCH_W   = 1,
  parameter int                N_REDIR   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REDIR-1:0]        redir_valid_i,
  input  logic [N_REDIR*ADDR_W-1:0] redir_target_i,
  input  logic                      fetch_ready_i,
  output logic [ADDR_W-1:0]         pc_o,
  output logic                      pc_valid_o,
  output logic                      redir_pending_o,
  output logic                      addr_err_o
);

  localparam int IDX_W = (N_REDIR > 1) ? $clog2(N_REDIR) : 1;
  localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(4 * FETCH_W);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~(BLK_BYTES - ADDR_W'(1));

  // State
  logic [ADDR_W-1:0] r_pc;
  logic              r_pc_valid;
  logic              r_pend_valid;
  logic [IDX_W-1:0]  r_pend_idx;
  logic [ADDR_W-1:0] r_pend_tgt;

  // Combinational decisions
  logic              w_accept;
  logic              w_in_any;
  logic [IDX_W-1:0]  w_in_idx;
  logic [ADDR_W-1:0] w_in_tgt;
  logic              w_take_in;
  logic              w_win_valid;
  logic [IDX_W-1:0]  w_win_idx;
  logic [ADDR_W-1:0] w_win_tgt;
  logic [ADDR_W-1:0] w_load_tgt;
  logic [ADDR_W-1:0] w_seq_pc;

  assign w_accept = r_pc_valid & fetch_ready_i;
  assign w_in_any = |redir_valid_i;
  assign w_seq_pc = (r_pc & BLK_MASK) + BLK_BYTES;

  // Pick the lowest-index incoming redirect (scan high to low so the last hit wins).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_in_idx = '0;
    w_in_tgt = '0;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        w_in_idx = IDX_W'(i);
        w_in_tgt = redir_target_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Arbitrate incoming winner against the pending entry; incoming wins ties.
  always_comb begin
    w_take_in   = w_in_any && (!r_pend_valid || (w_in_idx <= r_pend_idx));
    w_win_valid = w_in_any | r_pend_valid;
    w_win_idx   = w_take_in ? w_in_idx : r_pend_idx;
    w_win_tgt   = w_take_in ? w_in_tgt : r_pend_tgt;
  end

`ifdef ADDR_ERR_CHECK_EN
  logic r_addr_err;
  logic w_load_err;

  assign w_load_tgt = w_win_tgt;
  assign w_load_err = |w_win_tgt[1:0];
  assign addr_err_o = r_addr_err;

  // Error flag follows the most recent load: set by a misaligned redirect, cleared by any other load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (w_accept) begin
      r_addr_err <= w_win_valid ? w_load_err : 1'b0;
    end
  end
`else
  assign w_load_tgt = w_win_tgt & ~ADDR_W'(3);
  assign addr_err_o = 1'b0;
`endif

  // PC, valid and pending-redirect registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_pc         <= RESET_VEC;
      r_pc_valid   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_tgt   <= '0;
    end else begin
      r_pc_valid <= 1'b1;
      if (w_accept) begin
        // Redirect (incoming or pending) takes precedence over sequential advance.
        r_pc         <= w_win_valid ? w_load_tgt : w_seq_pc;
        r_pend_valid <= 1'b0;
      end else if (w_win_valid) begin
        // Stalled: PC held; the current winner becomes (or stays) the pending entry.
        r_pend_valid <= 1'b1;
        r_pend_idx   <= w_win_idx;
        r_pend_tgt   <= w_win_tgt;
      end
    end
  end

  assign pc_o            = r_pc;
  assign pc_valid_o      = r_pc_valid;
  assign redir_pending_o = r_pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen. Main instance uses FETCH_W=1;
// a second FETCH_W=4 instance shares the stimulus and is checked in a
// hand-written block-advance sequence.
module tb_pc_gen;

  localparam int AW = 32;
  localparam logic [AW-1:0] RV = 32'hBFC00000;

`ifdef ADDR_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    redir_valid;
  logic [3*AW-1:0] redir_target;
  logic          fetch_ready;

  logic [AW-1:0] pc1, pc4;
  logic          v1, v4, p1, p4, e1, e4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(AW), .RESET_VEC(RV), .FETCH_W(1), .N_REDIR(3)) dut (
    .clk(clk), .rst(rst), .redir_valid_i(redir_valid), .redir_target_i(redir_target),
    .fetch_ready_i(fetch_ready), .pc_o(pc1), .pc_valid_o(v1),
    .redir_pending_o(p1), .addr_err_o(e1)
  );

  pc_gen #(.ADDR_W(AW), .RESET_VEC(RV), .FETCH_W(4), .N_REDIR(3)) dut4 (
    .clk(clk), .rst(rst), .redir_valid_i(redir_valid), .redir_target_i(redir_target),
    .fetch_ready_i(fetch_ready), .pc_o(pc4), .pc_valid_o(v4),
    .redir_pending_o(p4), .addr_err_o(e4)
  );

  typedef struct {
    logic          rst;
    logic          rdy;
    logic [2:0]    rv;
    logic [AW-1:0] t0, t1, t2;
    logic [AW-1:0] pc;
    logic          valid;
    logic          pend;
    logic          err;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic rdy, input logic [2:0] rv,
                              input logic [AW-1:0] t0, input logic [AW-1:0] t1,
                              input logic [AW-1:0] t2, input logic [AW-1:0] pc,
                              input logic valid, input logic pend, input logic err);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.pc = pc; v.valid = valid; v.pend = pend; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge; outputs sampled 1ns after the next rising edge.
  task automatic apply(input logic r, input logic rdy, input logic [2:0] rv,
                       input logic [AW-1:0] t0, input logic [AW-1:0] t1, input logic [AW-1:0] t2);
    @(negedge clk);
    rst          = r;
    fetch_ready  = rdy;
    redir_valid  = rv;
    redir_target = {t2, t1, t0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; redir_valid = '0; redir_target = '0;

    // Reset, sequential advance (test 1)
    vecs[0]  = mk(1, 1, 3'b000, 0, 0, 0, RV, 0, 0, 0);
    vecs[1]  = mk(1, 1, 3'b000, 0, 0, 0, RV, 0, 0, 0);
    vecs[2]  = mk(1, 1, 3'b000, 0, 0, 0, RV, 0, 0, 0);
    vecs[3]  = mk(0, 1, 3'b000, 0, 0, 0, RV, 1, 0, 0);
    vecs[4]  = mk(0, 1, 3'b000, 0, 0, 0, 32'hBFC00004, 1, 0, 0);
    vecs[5]  = mk(0, 1, 3'b000, 0, 0, 0, 32'hBFC00008, 1, 0, 0);
    // Stalled redirects: pending keeps ch1, drops later ch2 (test 3)
    vecs[6]  = mk(0, 0, 3'b100, 0, 0, 32'h1000, 32'hBFC00008, 1, 1, 0);
    vecs[7]  = mk(0, 0, 3'b010, 0, 32'h2000, 0, 32'hBFC00008, 1, 1, 0);
    vecs[8]  = mk(0, 0, 3'b100, 0, 0, 32'h3000, 32'hBFC00008, 1, 1, 0);
    vecs[9]  = mk(0, 1, 3'b000, 0, 0, 0, 32'h2000, 1, 0, 0);
    vecs[10] = mk(0, 1, 3'b000, 0, 0, 0, 32'h2004, 1, 0, 0);
    // Same-cycle ch0 and ch2 (test 4)
    vecs[11] = mk(0, 1, 3'b101, 32'hBFC00380, 0, 32'h4000, 32'hBFC00380, 1, 0, 0);
    // Wrap, then reset discards pending (test 5)
    vecs[12] = mk(0, 1, 3'b010, 0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 0, 0);
    vecs[13] = mk(0, 1, 3'b000, 0, 0, 0, 32'h00000000, 1, 0, 0);
    vecs[14] = mk(0, 0, 3'b100, 0, 0, 32'h5000, 32'h00000000, 1, 1, 0);
    vecs[15] = mk(1, 0, 3'b000, 0, 0, 0, RV, 0, 0, 0);
    // Redirect while pc_valid is still 0 goes to pending
    vecs[16] = mk(0, 1, 3'b010, 0, 32'h6000, 0, RV, 1, 1, 0);
    vecs[17] = mk(0, 1, 3'b000, 0, 0, 0, 32'h6000, 1, 0, 0);
    // Equal index: incoming replaces pending
    vecs[18] = mk(0, 0, 3'b010, 0, 32'h7000, 0, 32'h6000, 1, 1, 0);
    vecs[19] = mk(0, 0, 3'b010, 0, 32'h7100, 0, 32'h6000, 1, 1, 0);
    vecs[20] = mk(0, 1, 3'b000, 0, 0, 0, 32'h7100, 1, 0, 0);
    // Misaligned targets (test 6)
    vecs[21] = mk(0, 1, 3'b001, 32'h1002, 0, 0, ERR_ON ? 32'h1002 : 32'h1000, 1, 0, ERR_ON);
    vecs[22] = mk(0, 1, 3'b000, 0, 0, 0, 32'h1004, 1, 0, 0);
    vecs[23] = mk(0, 1, 3'b100, 0, 0, 32'h2002, ERR_ON ? 32'h2002 : 32'h2000, 1, 0, ERR_ON);
    vecs[24] = mk(0, 0, 3'b000, 0, 0, 0, ERR_ON ? 32'h2002 : 32'h2000, 1, 0, ERR_ON);
    vecs[25] = mk(0, 1, 3'b001, 32'h3000, 0, 0, 32'h3000, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].t0, vecs[i].t1, vecs[i].t2);
      check($sformatf("v%0d.pc", i),    pc1,        vecs[i].pc);
      check($sformatf("v%0d.valid", i), AW'(v1),    AW'(vecs[i].valid));
      check($sformatf("v%0d.pend", i),  AW'(p1),    AW'(vecs[i].pend));
      check($sformatf("v%0d.err", i),   AW'(e1),    AW'(vecs[i].err));
    end

    // FETCH_W=4: redirect to mid-block target, then advance to next aligned 16-byte block (test 2)
    apply(1, 1, 3'b000, 0, 0, 0);
    check("fw4.reset_pc", pc4, RV);
    check("fw4.reset_valid", AW'(v4), AW'(0));
    apply(0, 1, 3'b000, 0, 0, 0);
    check("fw4.first_pc", pc4, RV);
    apply(0, 1, 3'b100, 0, 0, 32'h80000014);
    check("fw4.redir_pc", pc4, 32'h80000014);
    check("fw4.redir_pend", AW'(p4), AW'(0));
    apply(0, 1, 3'b000, 0, 0, 0);
    check("fw4.block_pc", pc4, 32'h80000020);
    apply(0, 1, 3'b000, 0, 0, 0);
    check("fw4.block2_pc", pc4, 32'h80000030);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
